// File: rtl/rv64g_pkg.sv
// Shared RV64G architectural constants for the register lock scoreboard.
// Lockable registers are the 32 integer plus the 32 floating-point registers.
package rv64g_pkg;
   localparam int NUM_REGS     = 64;
   localparam int NUM_WB_PORTS = 2;
   localparam int RIW          = $clog2(NUM_REGS);
   localparam int CNTW         = $clog2(NUM_REGS + 1);

   typedef logic [RIW-1:0] reg_idx_t;
endpackage

// File: rtl/wb_clr_decoder.sv
// Writeback clear decoder: turns NUM_WB (valid, index) pairs into one NR-bit
// clear mask (one-hot per port, OR-ed together). Index 0 (x0) and any index
// >= NR never produce a mask bit. Several ports on the same index collapse
// into a single bit.
module wb_clr_decoder
   import rv64g_pkg::*;
#(
   parameter int NR     = NUM_REGS,
   parameter int NUM_WB = NUM_WB_PORTS
) (
   input  logic     [NUM_WB-1:0] wb_valid_i,
   input  reg_idx_t [NUM_WB-1:0] wb_rd_i,
   output logic     [NR-1:0]     clr_mask_o
);

   logic [NR-1:0] port_mask [NUM_WB];

   generate
      for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_port
         // One-hot decode of a single port; loop starts at 1 so x0 is skipped.
         always_comb begin
            port_mask[gi] = '0;
            for (int i = 1; i < NR; i++) begin
               if (wb_valid_i[gi] && (wb_rd_i[gi] == RIW'(i)))
                  port_mask[gi][i] = 1'b1;
            end
         end
      end
   endgenerate

   // Merge all ports into one clear mask.
   always_comb begin
      clr_mask_o = '0;
      for (int p = 0; p < NUM_WB; p++)
         clr_mask_o = clr_mask_o | port_mask[p];
   end

endmodule

// File: rtl/reg_lock_scbd.sv
// Register lock scoreboard: one lock bit per architectural register, set on a
// granted issue, cleared on writeback, dropped entirely on flush. Also reports
// the registered popcount and a pulse for writebacks to unlocked registers.
// Optional macro REG_LOCK_WB_BYPASS_EN: when defined, registers written back
// this cycle already appear unlocked on locks_o (flush is never bypassed).
module reg_lock_scbd
   import rv64g_pkg::*;
#(
   parameter int NUM_WB = NUM_WB_PORTS
) (
   input  logic                     clk_i,
   input  logic                     arst_ni,
   input  logic                     set_valid_i,
   input  logic     [NUM_REGS-1:0]  set_mask_i,
   input  logic     [NUM_WB-1:0]    wb_valid_i,
   input  reg_idx_t [NUM_WB-1:0]    wb_rd_i,
   input  logic                     flush_i,
   output logic     [NUM_REGS-1:0]  locks_o,
   output logic     [CNTW-1:0]      lock_cnt_o,
   output logic                     wb_err_o
);

   localparam int NR = NUM_REGS;

   logic [NR-1:0]   lock_reg, lock_next;
   logic [CNTW-1:0] cnt_reg, cnt_next;
   logic            err_reg, err_next;
   logic [NR-1:0]   wb_clr_mask;
   logic [NR-1:0]   set_eff;

   wb_clr_decoder #(
      .NR     (NR),
      .NUM_WB (NUM_WB)
   ) u_wb_clr_decoder (
      .wb_valid_i (wb_valid_i),
      .wb_rd_i    (wb_rd_i),
      .clr_mask_o (wb_clr_mask)
   );

   // Next lock state: flush wins, then set beats clear; x0 can never lock.
   always_comb begin
      set_eff   = '0;
      lock_next = lock_reg;
      err_next  = 1'b0;
      if (set_valid_i)
         set_eff = set_mask_i & ~NR'(1);
      if (flush_i) begin
         lock_next = '0;
      end else begin
         lock_next = (lock_reg & ~wb_clr_mask) | set_eff;
         // A writeback is only legal against a held lock; a same-cycle set
         // re-arms the bit so it does not count as an error.
         err_next  = |(wb_clr_mask & ~lock_reg & ~set_eff);
      end
   end

   // Popcount of the next lock vector so the count lands on the same edge.
   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < NR; i++)
         cnt_next = cnt_next + CNTW'(lock_next[i]);
   end

   // State registers: lock vector, count and error pulse.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         lock_reg <= '0;
         cnt_reg  <= '0;
         err_reg  <= 1'b0;
      end else begin
         lock_reg <= lock_next;
         cnt_reg  <= cnt_next;
         err_reg  <= err_next;
      end
   end

`ifdef REG_LOCK_WB_BYPASS_EN
   // Writebacks in flight already release their lock towards the checker.
   assign locks_o = lock_reg & ~wb_clr_mask;
`else
   // Checker sees only the registered lock vector.
   assign locks_o = lock_reg;
`endif
   assign lock_cnt_o = cnt_reg;
   assign wb_err_o   = err_reg;

endmodule

// File: tb/tb_reg_lock_scbd.sv
// Directed testbench for reg_lock_scbd: expected outputs are queued as each
// step is driven and compared after the following rising edge.
module tb_reg_lock_scbd;
   import rv64g_pkg::*;

   localparam int NW = NUM_WB_PORTS;

   logic                   clk_i;
   logic                   arst_ni;
   logic                   set_valid_i;
   logic [NUM_REGS-1:0]    set_mask_i;
   logic [NW-1:0]          wb_valid_i;
   reg_idx_t [NW-1:0]      wb_rd_i;
   logic                   flush_i;
   logic [NUM_REGS-1:0]    locks_o;
   logic [CNTW-1:0]        lock_cnt_o;
   logic                   wb_err_o;

   typedef struct {
      string               tag;
      logic [NUM_REGS-1:0] locks;
      logic [CNTW-1:0]     cnt;
      logic                err;
   } exp_t;

   exp_t exp_q [$];
   int   n_assert = 0;
   int   n_fail   = 0;

   reg_lock_scbd dut (
      .clk_i       (clk_i),
      .arst_ni     (arst_ni),
      .set_valid_i (set_valid_i),
      .set_mask_i  (set_mask_i),
      .wb_valid_i  (wb_valid_i),
      .wb_rd_i     (wb_rd_i),
      .flush_i     (flush_i),
      .locks_o     (locks_o),
      .lock_cnt_o  (lock_cnt_o),
      .wb_err_o    (wb_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [NUM_REGS-1:0] bit_of(input int i);
      logic [NUM_REGS-1:0] m;
      m = '0;
      m[i] = 1'b1;
      return m;
   endfunction

   task automatic push_exp(input string tag, input logic [NUM_REGS-1:0] locks,
                           input int cnt, input logic err);
      exp_t e;
      e.tag   = tag;
      e.locks = locks;
      e.cnt   = CNTW'(cnt);
      e.err   = err;
      exp_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare against the current outputs.
   task automatic check_now();
      exp_t e;
      n_assert++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries, expected >= 1");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_assert++;
         assert (locks_o === e.locks) else begin
            n_fail++;
            $error("FAIL %s.locks: observed %h expected %h", e.tag, locks_o, e.locks);
         end
         n_assert++;
         assert (lock_cnt_o === e.cnt) else begin
            n_fail++;
            $error("FAIL %s.cnt: observed %0d expected %0d", e.tag, lock_cnt_o, e.cnt);
         end
         n_assert++;
         assert (wb_err_o === e.err) else begin
            n_fail++;
            $error("FAIL %s.err: observed %b expected %b", e.tag, wb_err_o, e.err);
         end
         $display("txn %-14s locks=%h cnt=%0d err=%b", e.tag, locks_o, lock_cnt_o, wb_err_o);
      end
   endtask

   task automatic tick_check();
      @(posedge clk_i);
      #1;
      check_now();
   endtask

   task automatic idle();
      set_valid_i = 1'b0;
      set_mask_i  = '0;
      wb_valid_i  = '0;
      wb_rd_i     = '0;
      flush_i     = 1'b0;
   endtask

   task automatic wb(input int port, input int rd);
      wb_valid_i[port] = 1'b1;
      wb_rd_i[port]    = RIW'(rd);
   endtask

   logic [NUM_REGS-1:0] ten_mask;

   initial begin
      // 1: reset held with random inputs
      arst_ni     = 1'b0;
      set_valid_i = 1'b1;
      set_mask_i  = {$urandom(), $urandom()};
      wb_valid_i  = NW'($urandom());
      wb_rd_i     = '{default: RIW'($urandom())};
      flush_i     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_mask_i = {$urandom(), $urandom()};
         push_exp("reset", '0, 0, 1'b0);
         tick_check();
      end
      idle();
      arst_ni = 1'b1;
      push_exp("release", '0, 0, 1'b0);
      tick_check();

      // 2: set bits 5 and 40, then clear 5 via port 0
      set_valid_i = 1'b1;
      set_mask_i  = bit_of(5) | bit_of(40);
      push_exp("set_5_40", bit_of(5) | bit_of(40), 2, 1'b0);
      tick_check();
      idle();
      wb(0, 5);
`ifdef REG_LOCK_WB_BYPASS_EN
      #1;
      push_exp("bypass_5", bit_of(40), 2, 1'b0);
      check_now();
`endif
      push_exp("clr_5", bit_of(40), 1, 1'b0);
      tick_check();

      // 3: set/clear collision on bit 7
      idle();
      set_valid_i = 1'b1;
      set_mask_i  = bit_of(7);
      push_exp("set_7", bit_of(7) | bit_of(40), 2, 1'b0);
      tick_check();
      wb(0, 7);
      push_exp("collide_7", bit_of(7) | bit_of(40), 2, 1'b0);
      tick_check();
      idle();
      wb(1, 7);
      push_exp("clr_7", bit_of(40), 1, 1'b0);
      tick_check();

      // 4: x0 never locks; double writeback to the same index
      idle();
      set_valid_i = 1'b1;
      set_mask_i  = bit_of(0) | bit_of(3);
      push_exp("set_0_3", bit_of(3) | bit_of(40), 2, 1'b0);
      tick_check();
      idle();
      wb(0, 3);
      wb(1, 3);
      push_exp("dbl_wb_3", bit_of(40), 1, 1'b0);
      tick_check();
      idle();
      wb(0, 0);
      push_exp("wb_x0", bit_of(40), 1, 1'b0);
      tick_check();

      // 5: writeback to an unlocked register pulses the error once
      idle();
      wb(1, 12);
      push_exp("err_12", bit_of(40), 1, 1'b1);
      tick_check();
      idle();
      push_exp("err_gone", bit_of(40), 1, 1'b0);
      tick_check();

      // 6: flush with simultaneous set and writeback
      ten_mask = bit_of(1) | bit_of(2) | bit_of(4) | bit_of(6) | bit_of(8) |
                 bit_of(20) | bit_of(30) | bit_of(50) | bit_of(63);
      set_valid_i = 1'b1;
      set_mask_i  = ten_mask;
      push_exp("set_ten", ten_mask | bit_of(40), 10, 1'b0);
      tick_check();
      idle();
      flush_i     = 1'b1;
      set_valid_i = 1'b1;
      set_mask_i  = bit_of(9);
      wb(0, 4);
      push_exp("flush", '0, 0, 1'b0);
      tick_check();
      idle();
      flush_i = 1'b1;
      wb(0, 12);
      push_exp("flush_no_err", '0, 0, 1'b0);
      tick_check();

      // 6b: async reset mid-sequence clears state without a clock edge
      idle();
      set_valid_i = 1'b1;
      set_mask_i  = bit_of(3) | bit_of(5);
      wb(1, 12);
      push_exp("pre_reset", bit_of(3) | bit_of(5), 2, 1'b1);
      tick_check();
      idle();
      #2;
      arst_ni = 1'b0;
      #1;
      push_exp("async_reset", '0, 0, 1'b0);
      check_now();
      @(negedge clk_i);
      arst_ni = 1'b1;
      push_exp("post_reset", '0, 0, 1'b0);
      tick_check();

      n_assert++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
